// File: rtl/bootram_bus_bridge_if.sv
// PicoRV32 native memory bus as seen by the boot RAM bridge.
// The CPU side drives requests; the bridge returns ready and read data.
interface bootram_bus_bridge_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/bootram_bus_bridge.sv
// Turns 32-bit PicoRV32 word accesses into four byte-serial cycles on the
// 8-bit single-port boot RAM, little-endian, with all RAM-side outputs registered.
module bootram_bus_bridge #(
    parameter int RAM_AW = 11
) (
    input  logic              clk,
    input  logic              reset,
    bootram_bus_bridge_if.slave bus,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_reset,
    output logic              ram_wre,
    output logic [RAM_AW-1:0] ram_ad,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);
    localparam int IW = RAM_AW - 2;

    typedef enum logic [2:0] {IDLE, WR, RD, RDLAST, DONE} state_t;

    state_t      state, state_n;
    logic [1:0]  k, k_n;
    logic [IW-1:0] idx;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [23:0] shadow;
    logic [31:0] rdata_q;
    logic        ready_q;

    logic              accept;
    logic              ce_n, wre_n, ready_n;
    logic [RAM_AW-1:0] ad_n;
    logic [7:0]        din_n;

    // Word-aligned and aliased: only the word-index bits of the address matter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[31:RAM_AW], bus.mem_addr[1:0]};

    assign ram_oce       = 1'b1;
    assign ram_reset     = reset;
    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

    // Next state plus the next value of every registered RAM-side output,
    // so each byte cycle presents its address/data exactly in its own cycle.
    always_comb begin
        state_n = state;
        k_n     = k;
        accept  = 1'b0;
        ce_n    = 1'b0;
        wre_n   = 1'b0;
        ready_n = 1'b0;
        ad_n    = ram_ad;
        din_n   = ram_din;
        case (state)
            IDLE: begin
                if (bus.mem_valid && !ready_q) begin
                    accept = 1'b1;
                    k_n    = 2'd0;
                    ad_n   = {bus.mem_addr[RAM_AW-1:2], 2'b00};
                    if (|bus.mem_wstrb) begin
                        state_n = WR;
                        din_n   = bus.mem_wdata[7:0];
                        ce_n    = bus.mem_wstrb[0];
                        wre_n   = bus.mem_wstrb[0];
                    end else begin
                        state_n = RD;
                        ce_n    = 1'b1;
                    end
                end
            end
            WR: begin
                if (k == 2'd3) begin
                    state_n = DONE;
                    ready_n = 1'b1;
                end else begin
                    k_n   = k + 2'd1;
                    ad_n  = {idx, k_n};
                    din_n = wdata_q[{k_n, 3'b000} +: 8];
                    ce_n  = wstrb_q[k_n];
                    wre_n = wstrb_q[k_n];
                end
            end
            RD: begin
                if (k == 2'd3) begin
                    state_n = RDLAST;
                end else begin
                    k_n  = k + 2'd1;
                    ad_n = {idx, k_n};
                    ce_n = 1'b1;
                end
            end
            RDLAST: begin
                state_n = DONE;
                ready_n = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                k_n     = 2'd0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= 2'd0;
        end else begin
            state <= state_n;
            k     <= k_n;
        end
    end

    // Read bytes arrive one cycle after their address, hence the k-1 capture slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            shadow  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            ram_ce  <= 1'b0;
            ram_wre <= 1'b0;
            ram_ad  <= '0;
            ram_din <= '0;
        end else begin
            if (accept) begin
                idx     <= bus.mem_addr[RAM_AW-1:2];
                wdata_q <= bus.mem_wdata;
                wstrb_q <= bus.mem_wstrb;
            end
            if (state == RD && k != 2'd0)
                shadow[{k - 2'd1, 3'b000} +: 8] <= ram_dout;
            if (state == RDLAST)
                rdata_q <= {ram_dout, shadow};
            ready_q <= ready_n;
            ram_ce  <= ce_n;
            ram_wre <= wre_n;
            ram_ad  <= ad_n;
            ram_din <= din_n;
        end
    end
endmodule

// File: tb/tb_bootram_bus_bridge.sv
// Directed bench for bootram_bus_bridge: table of word accesses against a
// behavioural byte RAM, plus reset sequences.
module tb_bootram_bus_bridge;
    logic        clk;
    logic        reset;
    logic        ram_ce, ram_oce, ram_reset, ram_wre;
    logic [10:0] ram_ad;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic [10:0] exp_base;
    } vec_t;

    vec_t vecs [9];

    bootram_bus_bridge_if bus_if ();

    bootram_bus_bridge #(.RAM_AW(11)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset),
        .ram_wre   (ram_wre),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Behavioural 2Kx8 RAM in bypass read mode; its reset clears only the output.
    logic [7:0] ram_mem [0:2047];
    always @(posedge clk) begin
        if (ram_reset)
            ram_dout <= 8'h00;
        else if (ram_ce && !ram_wre)
            ram_dout <= ram_mem[ram_ad];
        if (ram_ce && ram_wre)
            ram_mem[ram_ad] <= ram_din;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Called #1 after an edge while the bridge is idle; returns #1 into the first idle cycle after DONE.
    task automatic applyStimulus(input int id, input vec_t v);
        bit is_wr;
        is_wr = (v.wstrb != 4'b0000);
        bus_if.mem_valid = 1'b1;
        bus_if.mem_addr  = v.addr;
        bus_if.mem_wdata = v.wdata;
        bus_if.mem_wstrb = v.wstrb;
        @(posedge clk); #1;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_addr  = 32'h0000_0444;
        bus_if.mem_wdata = 32'h5A5A_5A5A;
        bus_if.mem_wstrb = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("v%0d ad b%0d", id, k), {21'b0, ram_ad}, {21'b0, v.exp_base + 11'(k)});
            checkOutput($sformatf("v%0d ready b%0d", id, k), {31'b0, bus_if.mem_ready}, 32'd0);
            if (is_wr) begin
                checkOutput($sformatf("v%0d ce b%0d", id, k), {31'b0, ram_ce}, {31'b0, v.wstrb[k]});
                checkOutput($sformatf("v%0d wre b%0d", id, k), {31'b0, ram_wre}, {31'b0, v.wstrb[k]});
                if (v.wstrb[k])
                    checkOutput($sformatf("v%0d din b%0d", id, k), {24'b0, ram_din}, {24'b0, v.wdata[8*k +: 8]});
            end else begin
                checkOutput($sformatf("v%0d ce b%0d", id, k), {31'b0, ram_ce}, 32'd1);
                checkOutput($sformatf("v%0d wre b%0d", id, k), {31'b0, ram_wre}, 32'd0);
            end
            @(posedge clk); #1;
        end
        if (!is_wr) begin
            checkOutput($sformatf("v%0d last ce", id), {31'b0, ram_ce}, 32'd0);
            checkOutput($sformatf("v%0d last ready", id), {31'b0, bus_if.mem_ready}, 32'd0);
            @(posedge clk); #1;
            last_rdata = v.exp_rdata;
        end
        checkOutput($sformatf("v%0d done ready", id), {31'b0, bus_if.mem_ready}, 32'd1);
        checkOutput($sformatf("v%0d done rdata", id), bus_if.mem_rdata, last_rdata);
        checkOutput($sformatf("v%0d done ce", id), {31'b0, ram_ce}, 32'd0);
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d idle ready", id), {31'b0, bus_if.mem_ready}, 32'd0);
        checkOutput($sformatf("v%0d idle rdata", id), bus_if.mem_rdata, last_rdata);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    32'h0,         11'h010};
        vecs[1] = '{32'h0000_0010, 32'h0,         4'h0,    32'hDEAD_BEEF, 11'h010};
        vecs[2] = '{32'h0000_0010, 32'h1122_3344, 4'b0101, 32'h0,         11'h010};
        vecs[3] = '{32'h0000_0010, 32'h0,         4'h0,    32'hDE22_BE44, 11'h010};
        vecs[4] = '{32'h0000_07FE, 32'hCAFE_F00D, 4'hF,    32'h0,         11'h7FC};
        vecs[5] = '{32'h0000_07FD, 32'h0,         4'h0,    32'hCAFE_F00D, 11'h7FC};
        vecs[6] = '{32'h1000_0010, 32'h0,         4'h0,    32'hDE22_BE44, 11'h010};
        vecs[7] = '{32'h0000_0813, 32'h7766_5544, 4'b1000, 32'h0,         11'h010};
        vecs[8] = '{32'h0000_0010, 32'h0,         4'h0,    32'h7722_BE44, 11'h010};

        last_rdata       = 32'h0;
        reset            = 1'b1;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h0;
        bus_if.mem_wstrb = 4'h0;
        #1;
        checkOutput("rst ram_reset", {31'b0, ram_reset}, 32'd1);
        checkOutput("rst oce", {31'b0, ram_oce}, 32'd1);
        checkOutput("rst ce", {31'b0, ram_ce}, 32'd0);
        checkOutput("rst ready", {31'b0, bus_if.mem_ready}, 32'd0);
        checkOutput("rst rdata", bus_if.mem_rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("post rst ce c%0d", c), {31'b0, ram_ce}, 32'd0);
            checkOutput($sformatf("post rst wre c%0d", c), {31'b0, ram_wre}, 32'd0);
            checkOutput($sformatf("post rst ad c%0d", c), {21'b0, ram_ad}, 32'd0);
            checkOutput($sformatf("post rst din c%0d", c), {24'b0, ram_din}, 32'd0);
            checkOutput($sformatf("post rst ready c%0d", c), {31'b0, bus_if.mem_ready}, 32'd0);
        end
        checkOutput("post rst oce", {31'b0, ram_oce}, 32'd1);
        checkOutput("post rst ram_reset", {31'b0, ram_reset}, 32'd0);
        checkOutput("post rst rdata", bus_if.mem_rdata, 32'd0);

        for (int i = 0; i < 9; i++)
            applyStimulus(i, vecs[i]);

        // Abort a read during its byte-2 issue cycle.
        bus_if.mem_valid = 1'b1;
        bus_if.mem_addr  = 32'h0000_0010;
        bus_if.mem_wstrb = 4'h0;
        @(posedge clk); #1;
        bus_if.mem_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort pre ad", {21'b0, ram_ad}, 32'h12);
        reset = 1'b1;
        #1;
        checkOutput("abort ce", {31'b0, ram_ce}, 32'd0);
        checkOutput("abort ad", {21'b0, ram_ad}, 32'd0);
        checkOutput("abort rdata", bus_if.mem_rdata, 32'd0);
        checkOutput("abort ram_reset", {31'b0, ram_reset}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("abort ready c%0d", c), {31'b0, bus_if.mem_ready}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        last_rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("abort idle ce c%0d", c), {31'b0, ram_ce}, 32'd0);
            checkOutput($sformatf("abort idle ready c%0d", c), {31'b0, bus_if.mem_ready}, 32'd0);
        end
        applyStimulus(9, vecs[8]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
